// File: rtl/seq_frame_pkg.sv
// Shared definitions for the 1010-sync serial framer and its matching receiver.
package seq_frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        PAR  = 2'd3
    } frame_state_t;

    localparam int          SYNC_W_DEF   = 4;
    localparam logic [3:0]  SYNC_PAT_DEF = 4'b1010;

    function automatic int frame_len(input int sync_w, input int data_w, input int parity_en);
        return sync_w + data_w + ((parity_en != 0) ? 1 : 0);
    endfunction

    localparam int FRAME_LEN_DEF = frame_len(SYNC_W_DEF, 8, 1);

endpackage

// File: rtl/seq_piso_shift.sv
// Parallel-in/serial-out payload register, MSB first, with running parity of shifted-out bits.
module seq_piso_shift #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              shift_en,
    output logic              msb,
    output logic              parity
);

    logic [DATA_W-1:0] sreg;
    logic              par_acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg    <= '0;
            par_acc <= 1'b0;
        end else if (load) begin
            sreg    <= load_data;
            par_acc <= 1'b0;
        end else if (shift_en) begin
            sreg    <= {sreg[DATA_W-2:0], 1'b0};
            par_acc <= par_acc ^ sreg[DATA_W-1];
        end
    end

    assign msb    = sreg[DATA_W-1];
    assign parity = par_acc;

endmodule

// File: rtl/seq_1010_framer_tx.sv
// Serial frame transmitter: sync pattern, payload MSB-first, optional even parity.
module seq_1010_framer_tx
    import seq_frame_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                SYNC_W    = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC_PAT  = SYNC_W'(SYNC_PAT_DEF),
    parameter int                PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              sout,
    output logic              sout_valid,
    output logic              frame_start,
    output logic              frame_done
);

    localparam int              CNT_W     = (DATA_W > SYNC_W) ? $clog2(DATA_W) : $clog2(SYNC_W);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam bit              PAR_ON    = (PARITY_EN != 0);

    frame_state_t      state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              hs, last_bit, shift_en, sout_n, done_n;
    logic              piso_msb, piso_par;
    logic [SYNC_W-1:0] sync_sh;

    // state/cnt describe the bit currently on sout; outputs register the next one
    assign last_bit = (state == PAR) || ((state == DATA) && (cnt == '0) && !PAR_ON);
    assign in_ready = (state == IDLE) || last_bit;
    assign hs       = in_valid && in_ready;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (hs) begin
                    state_n = SYNC;
                    cnt_n   = SYNC_LAST;
                end
            end
            SYNC: begin
                if (cnt == '0) begin
                    state_n = DATA;
                    cnt_n   = DATA_LAST;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            DATA: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (PAR_ON) begin
                    state_n = PAR;
                end else if (hs) begin
                    state_n = SYNC;
                    cnt_n   = SYNC_LAST;
                end else begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            PAR: begin
                if (hs) begin
                    state_n = SYNC;
                    cnt_n   = SYNC_LAST;
                end else begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_comb begin
        sync_sh  = SYNC_PAT >> cnt_n;
        shift_en = (state_n == DATA);
        done_n   = (state_n == PAR) || ((state_n == DATA) && (cnt_n == '0) && !PAR_ON);
        case (state_n)
            SYNC:    sout_n = sync_sh[0];
            DATA:    sout_n = piso_msb;
            PAR:     sout_n = piso_par;
            default: sout_n = 1'b0;
        endcase
    end

    seq_piso_shift #(
        .DATA_W(DATA_W)
    ) u_piso (
        .clk      (clk),
        .reset    (reset),
        .load     (hs),
        .load_data(in_data),
        .shift_en (shift_en),
        .msb      (piso_msb),
        .parity   (piso_par)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            sout        <= 1'b0;
            sout_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            sout        <= sout_n;
            sout_valid  <= (state_n != IDLE);
            frame_start <= hs;
            frame_done  <= done_n;
        end
    end

endmodule
